spi_master_tx: RTL and testbench
================================

SPI_MASTER_TX -- requirements
Module: spi_master_tx

Interface
REQ-001 Parameter DATA_WIDTH, default 32: word width popped from the TX FIFO.
REQ-002 Parameter CNT_WIDTH, default 16: width of the transfer bit-length field.
REQ-003 clk_i  input  1  system clock; all state on rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 en_i  input  1  start request, sampled in IDLE only.
REQ-006 clr_i  input  1  synchronous abort, highest priority after reset.
REQ-007 clkdiv_i  input  8  SCLK half-period minus one, in clk_i cycles.
REQ-008 len_i  input  CNT_WIDTH  total bits to send, latched on start.
REQ-009 data_i  input  DATA_WIDTH  FIFO head word.
REQ-010 data_valid_i  input  1  FIFO not empty.
REQ-011 data_ready_o  output  1  pop strobe to FIFO; a pop occurs when data_ready_o and data_valid_i are both high.
REQ-012 sclk_o  output  1  SPI clock, idle low (mode 0).
REQ-013 sdo_o  output  1  serial data out, MSB first.
REQ-014 busy_o  output  1  high in any state other than IDLE.
REQ-015 done_o  output  1  one-cycle pulse on normal completion.

Function
REQ-016 The block SHALL have states IDLE, LOAD, SHIFT, DONE.
REQ-017 IDLE->LOAD SHALL occur when en_i=1 and len_i!=0, latching len_i; en_i with len_i=0 SHALL be ignored; en_i outside IDLE SHALL be ignored.
REQ-018 In LOAD, data_ready_o SHALL equal data_valid_i (combinational); in all other states it SHALL be 0.
REQ-019 On a LOAD pop, the shift register SHALL load data_i, sdo_o SHALL become data_i[DATA_WIDTH-1] on the next cycle, and the state SHALL become SHIFT with divider count 0.
REQ-020 LOAD with data_valid_i=0 SHALL stall indefinitely, with sclk_o held low and sdo_o holding its last value.
REQ-021 In SHIFT, the divider SHALL increment each cycle; at count==clkdiv_i it SHALL reset to 0 and toggle sclk_o, giving a half-period of clkdiv_i+1 cycles (clkdiv_i=0 gives a SCLK of clk_i/2).
REQ-022 The rising toggle SHALL leave sdo_o unchanged (slave sample point).
REQ-023 On each falling toggle, the bit counter SHALL increment (modulo 2^CNT_WIDTH is unreachable because the counter is compared to len first).
REQ-024 At the falling toggle of bit number len (counting from 1), the state SHALL become DONE.
REQ-025 Otherwise, at the falling toggle of the last bit of a word (bit count a multiple of DATA_WIDTH), the state SHALL become LOAD.
REQ-026 Otherwise, at a falling toggle, the shift register SHALL shift left and sdo_o SHALL present the next bit in the same edge.
REQ-027 Partial last word: when len is not a multiple of DATA_WIDTH, only the upper len mod DATA_WIDTH bits of the final word SHALL be sent; the remaining bits SHALL be discarded; the word SHALL still be popped exactly once.
REQ-028 Words popped per transfer SHALL equal ceil(len/DATA_WIDTH).
REQ-029 DONE SHALL last one cycle with done_o=1, then return to IDLE.
REQ-030 In IDLE and DONE, sclk_o SHALL be 0 and sdo_o SHALL be 0.
REQ-031 clkdiv_i SHALL be sampled live; changing it mid-transfer is unsupported.
REQ-032 clr_i=1 in any state SHALL, on the next edge, force IDLE, clear the divider, bit counter and shift register, and drive sclk_o=0 and sdo_o=0, with no done_o pulse and no pop in that cycle (data_ready_o forced 0 while clr_i=1).

Reset
REQ-033 rst_ni=0 SHALL, asynchronously, force IDLE, zero all counters and the shift register, and drive sclk_o=0, sdo_o=0, busy_o=0, done_o=0 and data_ready_o=0, including mid-transfer.
REQ-034 After reset release, the first transfer SHALL begin only on a new en_i.

Verification
REQ-035 Single word: clkdiv_i=1, len_i=32, FIFO holds 0xA5A5_0F0F, en_i pulse -> one pop; 32 SCLK periods of 4 clk_i each; sdo_o sampled on rising edges yields 0xA5A50F0F MSB first; done_o high for 1 cycle; busy_o low afterwards.
REQ-036 Multi-word with underflow: len_i=64, first word 0x12345678 present, second word arrives 20 cycles after the first word ends -> sclk_o low during the gap; 64 bits equal 0x12345678 followed by the second word; exactly 2 pops.
REQ-037 Partial word: len_i=12, word 0xFFF0_0000, clkdiv_i=0 -> 12 rising edges all sampling 1; 1 pop; done_o asserted after the 12th falling edge.
REQ-038 Ignored starts: en_i with len_i=0 -> busy_o stays 0; en_i pulsed while busy -> no restart and bit count unaffected.
REQ-039 Abort: clr_i asserted after 10 bits of len_i=32 -> next cycle IDLE, sclk_o=0, sdo_o=0, no done_o; a subsequent en_i transfers cleanly.
REQ-040 Async reset: rst_ni dropped mid-SHIFT between clock edges -> all outputs at reset values immediately, without waiting for an edge.

Source files
------------

// File: rtl/spi_master_tx.sv
// SPI mode-0 transmit-only master: pops words from a TX FIFO and shifts them out MSB first.
// The transfer length is counted in bits, so the final word may be sent only partially.
module spi_master_tx #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic                  clr_i,
  input  logic [7:0]            clkdiv_i,
  input  logic [CNT_WIDTH-1:0]  len_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  data_valid_i,
  output logic                  data_ready_o,
  output logic                  sclk_o,
  output logic                  sdo_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int unsigned WCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_e;

  state_e                state_q;
  logic [7:0]            div_q;
  logic [CNT_WIDTH-1:0]  bitcnt_q;
  logic [CNT_WIDTH-1:0]  bitcnt_d;
  logic [CNT_WIDTH-1:0]  len_q;
  logic [WCW-1:0]        wcnt_q;
  logic [DATA_WIDTH-1:0] shreg_q;
  logic                  sclk_q;
  logic                  sdo_q;

  assign bitcnt_d = bitcnt_q + CNT_WIDTH'(1);

  // FIFO handshake is combinational so a pop completes in the LOAD cycle itself
  assign data_ready_o = (state_q == LOAD) && data_valid_i && !clr_i;

  assign sclk_o = sclk_q;
  assign sdo_o  = sdo_q;
  assign busy_o = (state_q != IDLE);
  assign done_o = (state_q == DONE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      div_q    <= '0;
      bitcnt_q <= '0;
      len_q    <= '0;
      wcnt_q   <= '0;
      shreg_q  <= '0;
      sclk_q   <= 1'b0;
      sdo_q    <= 1'b0;
    end else if (clr_i) begin
      state_q  <= IDLE;
      div_q    <= '0;
      bitcnt_q <= '0;
      wcnt_q   <= '0;
      shreg_q  <= '0;
      sclk_q   <= 1'b0;
      sdo_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          sclk_q <= 1'b0;
          sdo_q  <= 1'b0;
          if (en_i && (len_i != '0)) begin
            len_q    <= len_i;
            bitcnt_q <= '0;
            wcnt_q   <= '0;
            state_q  <= LOAD;
          end
        end
        LOAD: begin
          // Underflow stalls here with sclk low and sdo holding the last bit
          if (data_valid_i) begin
            shreg_q <= data_i;
            sdo_q   <= data_i[DATA_WIDTH-1];
            div_q   <= '0;
            wcnt_q  <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (div_q == clkdiv_i) begin
            div_q  <= '0;
            sclk_q <= ~sclk_q;
            // Only the falling toggle advances data; the rising one is the slave sample point
            if (sclk_q) begin
              bitcnt_q <= bitcnt_d;
              if (bitcnt_d == len_q) begin
                sdo_q   <= 1'b0;
                state_q <= DONE;
              end else if (wcnt_q == WCW'(DATA_WIDTH - 1)) begin
                state_q <= LOAD;
              end else begin
                shreg_q <= shreg_q << 1;
                sdo_q   <= shreg_q[DATA_WIDTH-2];
                wcnt_q  <= wcnt_q + WCW'(1);
              end
            end
          end else begin
            div_q <= div_q + 8'd1;
          end
        end
        DONE: begin
          sclk_q  <= 1'b0;
          sdo_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_tx.sv
// Bench for spi_master_tx: FIFO model, bit scoreboard sampled on SCLK rising edges,
// a table of transfers plus hand-written underflow, ignored-start, abort and reset sequences.
module tb_spi_master_tx;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en_i, clr_i;
  logic [7:0]    clkdiv_i;
  logic [CW-1:0] len_i;
  logic [DW-1:0] data_i;
  logic          data_valid_i;
  logic          data_ready_o, sclk_o, sdo_o, busy_o, done_o;

  always #5 clk = ~clk;

  spi_master_tx #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en_i), .clr_i(clr_i),
    .clkdiv_i(clkdiv_i), .len_i(len_i), .data_i(data_i),
    .data_valid_i(data_valid_i), .data_ready_o(data_ready_o),
    .sclk_o(sclk_o), .sdo_o(sdo_o), .busy_o(busy_o), .done_o(done_o)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] fifo[$];
  logic          exp_q[$];
  int            pops = 0, done_cnt = 0, rises = 0;
  int            cyc = 0, last_rise = 0, period = 0;
  bit            pop_pend = 1'b0;
  logic          sclk_prev = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // FIFO model: a pop seen before a rising edge is retired at the following falling edge
  always @(negedge clk) begin
    if (pop_pend && fifo.size() > 0) begin
      void'(fifo.pop_front());
      pops++;
    end
    #1;
    data_valid_i = (fifo.size() > 0);
    data_i       = (fifo.size() > 0) ? fifo[0] : '0;
    #3;
    pop_pend = data_ready_o && data_valid_i && rst_n;
  end

  // Scoreboard: every SCLK rise consumes one expected bit
  always @(negedge clk) begin
    cyc++;
    if (done_o) done_cnt++;
    if (sclk_o && !sclk_prev) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_sclk_rise: got rise with sdo=%0b, expected no rise (t=%0t)", sdo_o, $time);
      end else begin
        check("sdo_bit", 64'(sdo_o), 64'(exp_q.pop_front()));
      end
      if (period != 0 && rises > 0) check("sclk_period", 64'(cyc - last_rise), 64'(period));
      last_rise = cyc;
      rises++;
    end
    sclk_prev = sclk_o;
  end

  task automatic tick();
    @(negedge clk);
    #3;
  endtask

  task automatic start_xfer(input logic [7:0] div, input logic [CW-1:0] len,
                            input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                            input int nw, input bit preload_all);
    logic [DW-1:0] w;
    for (int k = 0; k < int'(len); k++) begin
      w = (k / DW == 0) ? w0 : w1;
      exp_q.push_back(w[DW-1-(k%DW)]);
    end
    fifo.push_back(w0);
    if (nw > 1 && preload_all) fifo.push_back(w1);
    clkdiv_i = div;
    len_i    = len;
    period   = (int'(len) <= DW) ? 2 * (int'(div) + 1) : 0;
    rises    = 0;
    en_i     = 1'b1;
    tick();
    en_i     = 1'b0;
    len_i    = '0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0 = done_cnt;
    int n  = 0;
    while (done_cnt == d0 && n < budget) begin
      tick();
      n++;
    end
    check({name, "_done_seen"}, 64'(done_cnt != d0), 64'd1);
  endtask

  task automatic wait_rises(input string name, input int target, input int budget);
    int n = 0;
    while (rises < target && n < budget) begin
      tick();
      n++;
    end
    check({name, "_rises_reached"}, 64'(rises >= target), 64'd1);
  endtask

  task automatic wait_sclk_low(input string name, input int budget);
    int n = 0;
    while (sclk_o !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    check({name, "_sclk_low"}, 64'(sclk_o), 64'd0);
  endtask

  task automatic finish_check(input string name, input int len, input int exp_pops,
                              input int p0, input int d0);
    repeat (3) tick();
    check({name, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
    check({name, "_pops"}, 64'(pops - p0), 64'(exp_pops));
    check({name, "_bits_left"}, 64'(exp_q.size()), 64'd0);
    check({name, "_rises"}, 64'(rises), 64'(len));
    check({name, "_idle_out"}, {61'd0, busy_o, sclk_o, sdo_o}, 64'd0);
  endtask

  typedef struct {
    string         name;
    logic [7:0]    div;
    logic [CW-1:0] len;
    logic [DW-1:0] w0;
    logic [DW-1:0] w1;
    int            nw;
    int            exp_pops;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, d0;

    vecs[0] = '{"single32",  8'd1, 16'd32, 32'hA5A5_0F0F, 32'h0,          1, 1};
    vecs[1] = '{"partial12", 8'd0, 16'd12, 32'hFFF0_0000, 32'h0,          1, 1};
    vecs[2] = '{"two40",     8'd2, 16'd40, 32'hDEAD_BEEF, 32'hC3FF_FFFF,  2, 2};
    vecs[3] = '{"one_bit",   8'd0, 16'd1,  32'h8000_0000, 32'h0,          1, 1};
    vecs[4] = '{"two33",     8'd0, 16'd33, 32'h0F0F_0F0F, 32'h8123_4567,  2, 2};

    rst_n = 1'b0; en_i = 1'b0; clr_i = 1'b0; clkdiv_i = '0; len_i = '0;
    data_i = '0; data_valid_i = 1'b0;
    repeat (2) tick();
    check("reset_outputs", {59'd0, data_ready_o, sclk_o, sdo_o, busy_o, done_o}, 64'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Table-driven transfers with the whole payload already in the FIFO
    for (int i = 0; i < 5; i++) begin
      p0 = pops; d0 = done_cnt;
      start_xfer(vecs[i].div, vecs[i].len, vecs[i].w0, vecs[i].w1, vecs[i].nw, 1'b1);
      wait_done(vecs[i].name, 5000);
      finish_check(vecs[i].name, int'(vecs[i].len), vecs[i].exp_pops, p0, d0);
    end

    // Underflow between words: SCLK must park low while the FIFO is empty
    p0 = pops; d0 = done_cnt;
    start_xfer(8'd1, 16'd64, 32'h1234_5678, 32'h9ABC_DEF0, 2, 1'b0);
    wait_rises("gap", 32, 2000);
    wait_sclk_low("gap", 20);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("gap_sclk_ready_busy", {61'd0, sclk_o, data_ready_o, busy_o}, 64'd1);
    end
    fifo.push_back(32'h9ABC_DEF0);
    wait_done("gap", 5000);
    finish_check("gap", 64, 2, p0, d0);

    // Start with zero length is ignored
    d0 = done_cnt;
    len_i = '0; en_i = 1'b1;
    tick();
    en_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("len0_busy", 64'(busy_o), 64'd0);
    end

    // Start request while busy is ignored
    p0 = pops; d0 = done_cnt;
    start_xfer(8'd0, 16'd16, 32'hABCD_1234, 32'h0, 1, 1'b1);
    wait_rises("busy_en", 5, 500);
    len_i = 16'd5; en_i = 1'b1;
    tick();
    en_i = 1'b0; len_i = '0;
    wait_done("busy_en", 2000);
    finish_check("busy_en", 16, 1, p0, d0);

    // Abort after ten bits
    d0 = done_cnt;
    start_xfer(8'd1, 16'd32, 32'hCAFE_F00D, 32'h0, 1, 1'b1);
    wait_rises("abort", 10, 500);
    wait_sclk_low("abort", 20);
    clr_i = 1'b1;
    tick();
    check("abort_outputs", {60'd0, busy_o, sclk_o, sdo_o, data_ready_o}, 64'd0);
    clr_i = 1'b0;
    exp_q.delete();
    repeat (3) tick();
    check("abort_no_done", 64'(done_cnt - d0), 64'd0);
    p0 = pops; d0 = done_cnt;
    start_xfer(vecs[0].div, vecs[0].len, vecs[0].w0, vecs[0].w1, 1, 1'b1);
    wait_done("after_abort", 5000);
    finish_check("after_abort", 32, 1, p0, d0);

    // Asynchronous reset between clock edges in the middle of shifting
    start_xfer(8'd1, 16'd32, 32'h1357_9BDF, 32'h0, 1, 1'b1);
    wait_rises("async_rst", 5, 500);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_outputs", {59'd0, data_ready_o, sclk_o, sdo_o, busy_o, done_o}, 64'd0);
    repeat (2) tick();
    exp_q.delete();
    fifo.delete();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_idle", 64'(busy_o), 64'd0);
    end
    p0 = pops; d0 = done_cnt;
    start_xfer(8'd0, 16'd12, 32'hFFF0_0000, 32'h0, 1, 1'b1);
    wait_done("after_rst", 2000);
    finish_check("after_rst", 12, 1, p0, d0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
